// File: rtl/store_buffer_pkg.sv
// Shared definitions for the post-commit store buffer: opcodes, widths and the
// FIFO entry record.
package store_buffer_pkg;

  localparam logic [6:0] SW_OPCODE = 7'b0100011;
  localparam logic [6:0] LW_OPCODE = 7'b0000011;

  // Storage width of one entry; the top casts its ADDR_W/DATA_W ports into these.
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-match selector for store-to-load forwarding: rotates the per-entry
// match vector so the oldest slot sits at bit 0, then picks the highest set bit.
module sb_fwd_select #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] wr_ptr,
  output logic             hit,
  output logic [PTR_W-1:0] sel_idx
);

  logic [DEPTH-1:0] rotated;

  // rotated[k] is slot wr_ptr+k; k = DEPTH-1 is the entry written last.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rotated[k] = match[wr_ptr + PTR_W'(k)];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit     = |rotated;
    sel_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rotated[k]) sel_idx = wr_ptr + PTR_W'(k);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order FIFO drained to data memory over req/ack,
// with combinational youngest-match forwarding to stage-4 loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     store_fifo_write_signal,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entry_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             enq;
  logic             deq;
  sb_entry_t        head;
  logic [DEPTH-1:0] match;
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_idx;

  // Word stores only: the byte offset of a load never affects the match.
  logic unused_ld_offset;
  assign unused_ld_offset = ^ld_addr[1:0];

  // Status and memory-side outputs decode registered state only.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign head      = entry_q[rd_ptr];
  assign mem_req   = !empty;
  assign mem_addr  = mem_req ? ADDR_W'(head.addr) : '0;
  assign mem_wdata = mem_req ? DATA_W'(head.data) : '0;

  // full comes from the registered count, so a full buffer rejects even when
  // the head is being acked in the same cycle.
  assign enq = store_fifo_write_signal && !full;
  assign deq = mem_req && mem_ack;

  // NOTE: the entry array is small, so it is reset in full; this keeps the
  // forwarding mux free of X even on slots that were never written.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (store_fifo_write_signal && full) overflow_q <= 1'b1;
      // enq and deq never hit the same slot: that needs count 0 or DEPTH.
      if (enq) begin
        entry_q[wr_ptr] <= '{valid: 1'b1,
                             addr:  SB_ADDR_W'(st_addr),
                             data:  SB_DATA_W'(st_data)};
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        entry_q[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The head being acked is still valid here; its valid bit clears next edge.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = entry_q[i].valid &&
                 (entry_q[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    end
  end

  sb_fwd_select #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_select (
    .match   (match),
    .wr_ptr  (wr_ptr),
    .hit     (fwd_hit),
    .sel_idx (fwd_idx)
  );

  assign ld_hit  = fwd_hit;
  assign ld_data = fwd_hit ? DATA_W'(entry_q[fwd_idx].data) : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit address/data).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        store_fifo_write_signal;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .store_fifo_write_signal (store_fifo_write_signal),
    .st_addr                 (st_addr),
    .st_data                 (st_data),
    .full                    (full),
    .empty                   (empty),
    .count                   (count),
    .overflow                (overflow),
    .mem_req                 (mem_req),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_ack                 (mem_ack),
    .ld_addr                 (ld_addr),
    .ld_hit                  (ld_hit),
    .ld_data                 (ld_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    store_fifo_write_signal = 1'b0;
    st_addr = '0;
    st_data = '0;
    mem_ack = 1'b0;
    ld_addr = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d);
    st_addr = a;
    st_data = d;
    store_fifo_write_signal = 1'b1;
    step();
    store_fifo_write_signal = 1'b0;
  endtask

  task automatic ack_one(input logic [31:0] exp_addr, input string name);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s: mem_req=%b mem_addr=%h, expected 1 / %h", name, mem_req, mem_addr, exp_addr);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({empty, full, count, mem_req, overflow, ld_hit} !== 8'b1_0_000_0_0_0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d req=%b ovf=%b hit=%b, expected 1 0 0 0 0 0",
               empty, full, count, mem_req, overflow, ld_hit);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || ld_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: mem_addr=%h mem_wdata=%h ld_data=%h, expected all 0", mem_addr, mem_wdata, ld_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    enq(32'h100, 32'hAAAA);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hAAAA || count !== 3'd1) begin
        errors++;
        $display("FAIL single_hold[%0d]: req=%b addr=%h wdata=%h count=%0d, expected 1 100 aaaa 1",
                 i, mem_req, mem_addr, mem_wdata, count);
      end
      step();
    end
    ack_one(32'h100, "single_drain_head");
    checks++;
    if (empty !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: empty=%b req=%b, expected 1 0", empty, mem_req);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'h10 * (i + 1), i + 1);
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill4: full=%b count=%0d ovf=%b, expected 1 4 0", full, count, overflow);
    end
    enq(32'h50, 32'h5);
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL enq5: full=%b count=%0d ovf=%b, expected 1 4 1", full, count, overflow);
    end
    ld_addr = 32'h50;
    #1;
    checks++;
    if (ld_hit !== 1'b0) begin
      errors++;
      $display("FAIL dropped_not_stored: ld_hit=%b, expected 0", ld_hit);
    end
    for (int i = 0; i < 4; i++) ack_one(32'h10 * (i + 1), "overflow_drain_order");
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drained: empty=%b ovf=%b, expected 1 1 (sticky)", empty, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    do_reset();
    // Single entry: enqueue + ack swaps the head.
    enq(32'h900, 32'h9);
    st_addr = 32'h904; st_data = 32'h94;
    store_fifo_write_signal = 1'b1; mem_ack = 1'b1;
    step();
    store_fifo_write_signal = 1'b0; mem_ack = 1'b0;
    checks++;
    if (count !== 3'd1 || mem_addr !== 32'h904 || mem_wdata !== 32'h94) begin
      errors++;
      $display("FAIL swap_count1: count=%0d addr=%h wdata=%h, expected 1 904 94", count, mem_addr, mem_wdata);
    end
    ack_one(32'h904, "swap_drain");
    // count=2 streaming for 8 cycles, pointers wrap twice.
    enq(32'h1000, 32'h0); exp_q.push_back(32'h1000);
    enq(32'h1004, 32'h1); exp_q.push_back(32'h1004);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem_addr !== exp_q[0]) begin
        errors++;
        $display("FAIL stream_head[%0d]: mem_addr=%h, expected %h", i, mem_addr, exp_q[0]);
      end
      st_addr = 32'h1008 + 32'(4 * i); st_data = 32'(i + 2);
      store_fifo_write_signal = 1'b1; mem_ack = 1'b1;
      step();
      store_fifo_write_signal = 1'b0; mem_ack = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(32'h1008 + 32'(4 * i));
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL stream_count[%0d]: count=%0d, expected 2", i, count);
      end
    end
    ack_one(exp_q[0], "stream_tail0");
    ack_one(exp_q[1], "stream_tail1");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_empty: empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_forward();
    do_reset();
    enq(32'h200, 32'h11);
    enq(32'h200, 32'h22);
    ld_addr = 32'h202;
    #1;
    checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_youngest: hit=%b data=%h, expected 1 22", ld_hit, ld_data);
    end
    ld_addr = 32'h204;
    #1;
    checks++;
    if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
      errors++;
      $display("FAIL fwd_miss: hit=%b data=%h, expected 0 0", ld_hit, ld_data);
    end
    // Not visible in the cycle it is being written, visible the next.
    st_addr = 32'h300; st_data = 32'h33; store_fifo_write_signal = 1'b1;
    ld_addr = 32'h300;
    #1;
    checks++;
    if (ld_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_same_cycle: hit=%b, expected 0", ld_hit);
    end
    step();
    store_fifo_write_signal = 1'b0;
    checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h33) begin
      errors++;
      $display("FAIL fwd_next_cycle: hit=%b data=%h, expected 1 33", ld_hit, ld_data);
    end
    ack_one(32'h200, "fwd_drain_first");
    // Head (0x200/0x22) is being acked this cycle: still forwards.
    ld_addr = 32'h200; mem_ack = 1'b1;
    #1;
    checks++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_acked_head: hit=%b data=%h, expected 1 22", ld_hit, ld_data);
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (ld_hit !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL fwd_after_drain: hit=%b count=%0d, expected 0 1", ld_hit, count);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'h400 + 32'(4 * i), 32'(i));
    st_addr = 32'h4F0; st_data = 32'hF; store_fifo_write_signal = 1'b1; mem_ack = 1'b1;
    step();
    store_fifo_write_signal = 1'b0; mem_ack = 1'b0;
    checks++;
    if (count !== 3'd3 || overflow !== 1'b1 || full !== 1'b0 || mem_addr !== 32'h404) begin
      errors++;
      $display("FAIL full_simul: count=%0d ovf=%b full=%b addr=%h, expected 3 1 0 404",
               count, overflow, full, mem_addr);
    end
    ack_one(32'h404, "full_simul_drain1");
    ack_one(32'h408, "full_simul_drain2");
    ack_one(32'h40C, "full_simul_drain3");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_simul_empty: empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) enq(32'h600 + 32'(4 * i), 32'(i));
    mem_ack = 1'b1;
    ld_addr = 32'h600;
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 3'd0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || ld_hit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: empty=%b count=%0d req=%b addr=%h hit=%b, expected 1 0 0 0 0",
               empty, count, mem_req, mem_addr, ld_hit);
    end
    step();
    reset_n = 1'b1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mem_req !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: req=%b count=%0d, expected 0 0", i, mem_req, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_forward();
    test_full_simul();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the memory stage and data memory. The pipeline control asserts `store_fifo_write_signal` while a store sits in stage 4, and this block captures address and data in a FIFO. It drains entries to data memory in order over a req/ack handshake. It also forwards buffered store data to younger loads, so a load never reads stale memory while a matching store is pending.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: store data width (word stores only).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `store_fifo_write_signal`  in  1  enqueue request from pipeline control.
- `st_addr`  in  ADDR_W  store byte address (z4).
- `st_data`  in  DATA_W  store data (datawrite mux output).
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `overflow`  out  1  sticky; set when an enqueue is attempted while full.
- `mem_req`  out  1  head entry valid (== !empty).
- `mem_addr`  out  ADDR_W  head entry address.
- `mem_wdata`  out  DATA_W  head entry data.
- `mem_ack`  in  1  memory accepted the head this cycle.
- `ld_addr`  in  ADDR_W  address of the load in stage 4.
- `ld_hit`  out  1  some valid entry matches `ld_addr`.
- `ld_data`  out  DATA_W  data of the youngest matching entry; 0 if no hit.

## Operation
- Circular FIFO with read pointer `rd_ptr`, write pointer `wr_ptr` (log2(DEPTH) bits, wrap modulo DEPTH), and a `count` register.
- Enqueue occurs when `store_fifo_write_signal && !full`: write `{st_addr, st_data}` at `wr_ptr`, then increment `wr_ptr`.
- Enqueue while full is dropped. `overflow` sets and holds until reset; no entry or pointer changes.
- Dequeue occurs when `mem_req && mem_ack`: increment `rd_ptr`. `mem_ack` while empty is ignored.
- Simultaneous enqueue and dequeue (not full):
  - both pointers advance and `count` is unchanged;
  - when count == 1, the old head drains and the new entry becomes head next cycle.
- Simultaneous enqueue and dequeue while full: `full` is decoded from registered `count`, so the enqueue is rejected (overflow sets) and only the dequeue happens.
- Forwarding:
  - compare `ld_addr[ADDR_W-1:2]` against every valid entry's address[ADDR_W-1:2];
  - priority goes to the youngest entry, i.e. the closest behind `wr_ptr`;
  - the head entry being acked this cycle still counts as valid for forwarding.
- `mem_addr`/`mem_wdata` hold stable while `mem_req` is high without an ack. The memory may assume this.
- Reset values: `rd_ptr`=`wr_ptr`=0, `count`=0, `overflow`=0, all entry valid bits 0. This gives `empty`=1, `full`=0, `mem_req`=0, `ld_hit`=0, `ld_data`=0, and `mem_addr`=`mem_wdata`=0.
- Reset asserted mid-drain discards all pending stores immediately (asynchronous); an ack in the same cycle has no effect.

## Timing
- Enqueue-to-`mem_req` latency: 1 cycle (entry visible the edge after capture).
- Throughput: one enqueue and one dequeue per cycle.
- `full`, `empty`, `count`, and `mem_*` are registered-state decodes with no combinational path from inputs.
- `ld_hit`/`ld_data` are combinational from `ld_addr` and state, and must resolve within the stage-4 cycle. A store enqueued on edge N is forwardable from cycle N+1; it is not forwarded in the cycle it is being written.
- The pipeline must stall on `full`; this block does not back-pressure.

## Structure
- Shared package `store_buffer_pkg`:
  - `SW_OPCODE = 7'b0100011`, `LW_OPCODE = 7'b0000011`;
  - typedef `sb_entry_t {valid, addr, data}`.
- Single module; the youngest-match priority select is natural as a sub-module `sb_fwd_select` (DEPTH match vector rotated by `wr_ptr`, then priority encode).

## Test plan
- Reset, then enqueue (0x100, 0xAAAA) with `mem_ack`=0 → next cycle `mem_req`=1, `mem_addr`=0x100, `mem_wdata`=0xAAAA, `count`=1; values held for 5 cycles.
- Enqueue 4 stores, then a 5th with DEPTH=4 → `full`=1, `overflow`=1, 5th lost. Then ack 4× → addresses drain in order and `empty`=1.
- Same cycle enqueue + ack with count=2 → `count` stays 2. Over 8 cycles, `wr_ptr` and `rd_ptr` wrap with order preserved.
- Enqueue (0x200, 0x11) then (0x200, 0x22); `ld_addr`=0x202 → `ld_hit`=1, `ld_data`=0x22. With `ld_addr`=0x204 → `ld_hit`=0, `ld_data`=0.
- Full buffer with enqueue + ack in the same cycle → dequeue only, `count`=3, `overflow`=1.
- Drop `reset_n` mid-cycle with 3 entries pending → outputs immediately return to reset values; no further `mem_req`.
